model_loader: RTL

- Framed, parametrised UART bulk loader for the graphics model memories (indices, positions, normals, materials, and future regions).
- Parses a byte stream from the uart block into per-region word writes over one generic write port.
- Supports a base-address offset for partial updates, per-region word width and depth, a checksum, timeout recovery and a one-byte status reply on tx.
- Sits between the uart instance and the region RAMs at model-memory top level.

---
 rtl/model_loader_pkg.sv | 40 ++++
 rtl/loader_timeout.sv | 41 ++++
 rtl/model_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/model_loader_pkg.sv
// Shared types and constants for the framed UART model-memory loader.
// Holds the parser state encoding, sync/response codes and parameter unpack helpers.
// Helpers take zero-extended parameter vectors so one package serves any region count.
package model_loader_pkg;

  // Largest region count the unpack helpers can address (4-bit region index).
  localparam int MAX_REGIONS = 16;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [7:0] RSP_ACK        = 8'h06;
  localparam logic [7:0] RSP_CSUM       = 8'h15;
  localparam logic [7:0] RSP_BAD_REGION = 8'h16;
  localparam logic [7:0] RSP_RANGE      = 8'h17;
  localparam logic [7:0] RSP_TIMEOUT    = 8'h18;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_REGION  = 4'd1,
    ST_BASE_HI = 4'd2,
    ST_BASE_LO = 4'd3,
    ST_CNT_HI  = 4'd4,
    ST_CNT_LO  = 4'd5,
    ST_PAYLOAD = 4'd6,
    ST_CHECK   = 4'd7,
    ST_RESP    = 4'd8
  } state_e;

  // Bytes per word for one region out of the packed 4-bit-per-region vector.
  function automatic logic [3:0] word_bytes(input logic [MAX_REGIONS*4-1:0] vec,
                                            input logic [3:0]               region);
    word_bytes = vec[int'(region)*4 +: 4];
  endfunction

  // Word depth for one region out of the packed 16-bit-per-region vector.
  function automatic logic [15:0] depth(input logic [MAX_REGIONS*16-1:0] vec,
                                        input logic [3:0]                region);
    depth = vec[int'(region)*16 +: 16];
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle watchdog for the loader: loadable down-counter, expired when it reaches zero.
// Latency: expired rises TIMEOUT_CYCLES-1 enabled cycles after the last clear.
// No backpressure; clear has priority over counting and holds the start value.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic en_in,
  output logic expired_out
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] START = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: reload on clear, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = START;
    end else if (en_in && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Counter register with synchronous reset to the start value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= START;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_out = (count_q == '0);

endmodule

// File: rtl/model_loader.sv
// Parses framed UART bytes into per-region word writes and replies with one status byte.
// Latency: write strobe one cycle after a word's last byte; reply one cycle after checksum.
// rx has no backpressure (bytes dropped while replying); tx reply held until tx_ready_in.
module model_loader
  import model_loader_pkg::*;
#(
  parameter int                        NUM_REGIONS       = 4,
  parameter int                        DATA_WIDTH        = 96,
  parameter int                        ADDR_WIDTH        = 16,
  parameter logic [4*NUM_REGIONS-1:0]  REGION_WORD_BYTES = {4'd12, 4'd12, 4'd12, 4'd5},
  parameter logic [16*NUM_REGIONS-1:0] REGION_DEPTH      = {16'd32, 16'd2048, 16'd2048, 16'd8192},
  parameter int                        TIMEOUT_CYCLES    = 1_000_000,
  localparam int                       RW                = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_valid_in,
  input  logic [7:0]            rx_byte_in,
  output logic                  tx_valid_out,
  output logic [7:0]            tx_byte_out,
  input  logic                  tx_ready_in,
  output logic                  wr_en_out,
  output logic [RW-1:0]         wr_region_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [DATA_WIDTH-1:0] wr_data_out,
  output logic                  busy_out,
  output logic                  frame_done_out
);

  localparam int                    WB_W        = MAX_REGIONS * 4;
  localparam int                    DP_W        = MAX_REGIONS * 16;
  localparam logic [WB_W-1:0]       WB_VEC      = WB_W'(REGION_WORD_BYTES);
  localparam logic [DP_W-1:0]       DP_VEC      = DP_W'(REGION_DEPTH);
  localparam logic [8:0]            NUM_REG_9   = 9'(NUM_REGIONS);

  state_e                  state_q,      state_d;
  logic [3:0]              region_q,     region_d;
  logic [15:0]             base_q,       base_d;
  logic [15:0]             cnt_q,        cnt_d;
  logic [15:0]             word_idx_q,   word_idx_d;
  logic [3:0]              byte_cnt_q,   byte_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
  logic [7:0]              sum_q,        sum_d;
  logic                    bad_region_q, bad_region_d;
  logic                    range_err_q,  range_err_d;
  logic                    wr_en_q,      wr_en_d;
  logic [RW-1:0]           wr_region_q,  wr_region_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q,    wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q,    wr_data_d;
  logic                    tx_valid_q,   tx_valid_d;
  logic [7:0]              tx_byte_q,    tx_byte_d;

  logic [3:0]  region_bpw;
  logic [3:0]  bpw_m1;
  logic [15:0] region_depth;
  logic [16:0] addr_sum;
  logic        addr_oor;
  logic        word_last;
  logic        frame_last;
  logic        to_clear;
  logic        to_expired;
  logic        frame_active;

  // Unknown regions still consume payload, one byte per word, so framing stays aligned.
  assign region_bpw   = word_bytes(WB_VEC, region_q);
  assign bpw_m1       = (bad_region_q || (region_bpw == 4'd0)) ? 4'd0 : (region_bpw - 4'd1);
  assign region_depth = depth(DP_VEC, region_q);
  // 17-bit sum so a base+index that wraps 16 bits still lands out of range.
  assign addr_sum     = {1'b0, base_q} + {1'b0, word_idx_q};
  assign addr_oor     = (addr_sum >= {1'b0, region_depth});
  assign word_last    = (byte_cnt_q == bpw_m1);
  assign frame_last   = (word_idx_q == (cnt_q - 16'd1));

  // The watchdog only runs mid-frame; any received byte restarts it.
  assign frame_active = (state_q != ST_IDLE) && (state_q != ST_RESP);
  assign to_clear     = rx_valid_in || !frame_active;

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (to_clear),
    .en_in       (!to_clear),
    .expired_out (to_expired)
  );

  // Frame parser, word assembly, write generation and reply selection.
  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    sum_d        = sum_q;
    bad_region_d = bad_region_q;
    range_err_d  = range_err_q;
    wr_en_d      = 1'b0;
    wr_region_d  = wr_region_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_in && (rx_byte_in == SYNC_BYTE)) begin
          state_d      = ST_REGION;
          sum_d        = 8'd0;
          bad_region_d = 1'b0;
          range_err_d  = 1'b0;
        end
      end
      ST_REGION: begin
        if (rx_valid_in) begin
          region_d     = rx_byte_in[3:0];
          bad_region_d = ({1'b0, rx_byte_in} >= NUM_REG_9);
          sum_d        = sum_q + rx_byte_in;
          state_d      = ST_BASE_HI;
        end
      end
      ST_BASE_HI: begin
        if (rx_valid_in) begin
          base_d[15:8] = rx_byte_in;
          sum_d        = sum_q + rx_byte_in;
          state_d      = ST_BASE_LO;
        end
      end
      ST_BASE_LO: begin
        if (rx_valid_in) begin
          base_d[7:0] = rx_byte_in;
          sum_d       = sum_q + rx_byte_in;
          state_d     = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid_in) begin
          cnt_d[15:8] = rx_byte_in;
          sum_d       = sum_q + rx_byte_in;
          state_d     = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid_in) begin
          cnt_d[7:0] = rx_byte_in;
          sum_d      = sum_q + rx_byte_in;
          word_idx_d = 16'd0;
          byte_cnt_d = 4'd0;
          state_d    = ({cnt_q[15:8], rx_byte_in} == 16'd0) ? ST_CHECK : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid_in) begin
          sum_d = sum_q + rx_byte_in;
          // First byte of a word starts from a clean register.
          if (byte_cnt_q == 4'd0) begin
            shift_d = DATA_WIDTH'(rx_byte_in);
          end else begin
            shift_d = (shift_q << 8) | DATA_WIDTH'(rx_byte_in);
          end
          if (word_last) begin
            byte_cnt_d = 4'd0;
            word_idx_d = word_idx_q + 16'd1;
            if (!bad_region_q) begin
              if (addr_oor) begin
                range_err_d = 1'b1;
              end else begin
                wr_en_d     = 1'b1;
                wr_region_d = region_q[RW-1:0];
                wr_addr_d   = ADDR_WIDTH'(base_q) + ADDR_WIDTH'(word_idx_q);
                wr_data_d   = shift_d;
              end
            end
            if (frame_last) begin
              state_d = ST_CHECK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      ST_CHECK: begin
        if (rx_valid_in) begin
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
          if (bad_region_q) begin
            tx_byte_d = RSP_BAD_REGION;
          end else if (range_err_q) begin
            tx_byte_d = RSP_RANGE;
          end else if (rx_byte_in != sum_q) begin
            tx_byte_d = RSP_CSUM;
          end else begin
            tx_byte_d = RSP_ACK;
          end
        end
      end
      ST_RESP: begin
        if (tx_valid_q && tx_ready_in) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte arriving on the terminal-count cycle keeps the frame alive.
    if (frame_active && !rx_valid_in && to_expired) begin
      state_d    = ST_RESP;
      tx_valid_d = 1'b1;
      tx_byte_d  = RSP_TIMEOUT;
    end
  end

  // State and output registers; reset abandons any frame and zeroes the outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      region_q     <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      sum_q        <= '0;
      bad_region_q <= 1'b0;
      range_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_region_q  <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      sum_q        <= sum_d;
      bad_region_q <= bad_region_d;
      range_err_q  <= range_err_d;
      wr_en_q      <= wr_en_d;
      wr_region_q  <= wr_region_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
    end
  end

  assign wr_en_out      = wr_en_q;
  assign wr_region_out  = wr_region_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign tx_valid_out   = tx_valid_q;
  assign tx_byte_out    = tx_byte_q;
  assign busy_out       = (state_q != ST_IDLE);
  assign frame_done_out = (state_q == ST_RESP) && tx_valid_q && tx_ready_in;

endmodule
